// File: rtl/csr_trap_unit_if.sv
// Commit/CSR/redirect bundle between the execute/commit stage, fetch and csr_trap_unit.
//   master : commit side, drives the committing instruction and accepts redirects
//            (inst_*, csr_*, redirect_ready out; csr_read, busy, redirect_* in)
//   slave  : csr_trap_unit side
interface csr_trap_unit_if #(
  parameter int unsigned XLEN = 64
) ();
  logic            inst_valid;
  logic [XLEN-1:0] inst_addr;
  logic [11:0]     csr_index;
  logic [1:0]      csr_ctrl;
  logic [XLEN-1:0] csr_wdata;
  logic            inst_ecall;
  logic            inst_ebreak;
  logic            inst_mret;
  logic [XLEN-1:0] csr_read;
  logic            busy;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;

  modport master (
    output inst_valid, inst_addr, csr_index, csr_ctrl, csr_wdata,
    output inst_ecall, inst_ebreak, inst_mret, redirect_ready,
    input  csr_read, busy, redirect_valid, redirect_pc
  );

  modport slave (
    input  inst_valid, inst_addr, csr_index, csr_ctrl, csr_wdata,
    input  inst_ecall, inst_ebreak, inst_mret, redirect_ready,
    output csr_read, busy, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller.
// Takes committed-instruction info, performs CSR read/modify/write, takes interrupts and
// ecall/ebreak exceptions, executes mret, and hands the new PC to fetch over a
// valid/ready handshake (busy stays high until fetch accepts).
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   bus (slave)         commit info, CSR operand/index, csr_read, busy, redirect handshake
//   ext_irq/sw_irq/timer_irq, local_irq  level interrupt lines (synchronised internally)
// Build option: define CSR_TRAP_UNIT_COUNTERS_EN to implement mcycle, minstret and
// mcountinhibit; without it those indices read 0 and no counter flops exist.
module csr_trap_unit #(
  parameter int unsigned    XLEN          = 64,
  parameter int unsigned    NUM_LOCAL_IRQ = 4,
  parameter logic [XLEN-1:0] RESET_MTVEC  = '0,
  localparam int unsigned   LirqW         = (NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1
) (
  input  logic             clk,
  input  logic             rst,
  csr_trap_unit_if.slave   bus,
  input  logic             ext_irq,
  input  logic             sw_irq,
  input  logic             timer_irq,
  input  logic [LirqW-1:0] local_irq
);

  localparam logic [11:0] AddrMstatus       = 12'h300;
  localparam logic [11:0] AddrMie           = 12'h304;
  localparam logic [11:0] AddrMtvec         = 12'h305;
  localparam logic [11:0] AddrMcountinhibit = 12'h320;
  localparam logic [11:0] AddrMscratch      = 12'h340;
  localparam logic [11:0] AddrMepc          = 12'h341;
  localparam logic [11:0] AddrMcause        = 12'h342;
  localparam logic [11:0] AddrMtval         = 12'h343;
  localparam logic [11:0] AddrMip           = 12'h344;
  localparam logic [11:0] AddrMcycle        = 12'hB00;
  localparam logic [11:0] AddrMinstret      = 12'hB02;

  localparam logic [63:0]     LocalMask = ((64'd1 << NUM_LOCAL_IRQ) - 64'd1) << 16;
  localparam logic [XLEN-1:0] MieMask   = XLEN'(LocalMask | 64'h888);

  typedef enum logic [0:0] {StIdle, StRedirect} state_e;
  state_e state_q, state_d;

  // Architectural state
  logic            mstatus_mie_q, mstatus_mpie_q;
  logic [XLEN-1:0] mtvec_q, mepc_q, mcause_q, mtval_q, mie_q, mscratch_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic [LirqW+2:0] irq_meta_q, irq_sync_q;

  logic [XLEN-1:0] mip_val, pending, csr_rdata, wval, tvec_base, next_pc;
  logic [4:0]      irq_cause;
  logic            commit, irq_take, exc_take, mret_take, trap, csr_we;

`ifdef CSR_TRAP_UNIT_COUNTERS_EN
  logic [XLEN-1:0] mcycle_q, minstret_q;
  logic            cy_inhibit_q, ir_inhibit_q;
  logic            retire;
`endif

  // Two-flop synchroniser for all interrupt levels: {local, ext, timer, sw}
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_meta_q <= '0;
      irq_sync_q <= '0;
    end else begin
      irq_meta_q <= {local_irq, ext_irq, timer_irq, sw_irq};
      irq_sync_q <= irq_meta_q;
    end
  end

  always_comb begin
    mip_val     = '0;
    mip_val[3]  = irq_sync_q[0];
    mip_val[7]  = irq_sync_q[1];
    mip_val[11] = irq_sync_q[2];
    for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
      mip_val[16+i] = irq_sync_q[3+i];
    end
  end

  assign pending = mip_val & mie_q & {XLEN{mstatus_mie_q}};

  // Fixed priority: later assignments win, so the highest priority is written last
  always_comb begin
    irq_cause = '0;
    for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
      if (pending[16+i]) irq_cause = 5'(16 + i);
    end
    if (pending[7])  irq_cause = 5'd7;
    if (pending[3])  irq_cause = 5'd3;
    if (pending[11]) irq_cause = 5'd11;
  end

  assign commit    = bus.inst_valid && (state_q == StIdle);
  assign irq_take  = commit && (|pending);
  assign exc_take  = commit && !irq_take && (bus.inst_ecall || bus.inst_ebreak);
  assign mret_take = commit && !irq_take && !exc_take && bus.inst_mret;
  assign trap      = irq_take || exc_take;
  assign csr_we    = commit && !trap && (bus.csr_ctrl != 2'b00);

  // Combinational read of the current (pre-update) value
  always_comb begin
    csr_rdata = '0;
    unique case (bus.csr_index)
      AddrMstatus: begin
        csr_rdata[12:11] = 2'b11;
        csr_rdata[7]     = mstatus_mpie_q;
        csr_rdata[3]     = mstatus_mie_q;
      end
      AddrMie:      csr_rdata = mie_q;
      AddrMtvec:    csr_rdata = mtvec_q;
      AddrMscratch: csr_rdata = mscratch_q;
      AddrMepc:     csr_rdata = mepc_q;
      AddrMcause:   csr_rdata = mcause_q;
      AddrMtval:    csr_rdata = mtval_q;
      AddrMip:      csr_rdata = mip_val;
`ifdef CSR_TRAP_UNIT_COUNTERS_EN
      AddrMcountinhibit: begin
        csr_rdata[0] = cy_inhibit_q;
        csr_rdata[2] = ir_inhibit_q;
      end
      AddrMcycle:   csr_rdata = mcycle_q;
      AddrMinstret: csr_rdata = minstret_q;
`endif
      default:      csr_rdata = '0;
    endcase
  end

  assign bus.csr_read = csr_rdata;

  always_comb begin
    unique case (bus.csr_ctrl)
      2'b01:   wval = bus.csr_wdata;
      2'b10:   wval = csr_rdata | bus.csr_wdata;
      2'b11:   wval = csr_rdata & ~bus.csr_wdata;
      default: wval = csr_rdata;
    endcase
  end

  // Vectored offset applies to interrupts only; exceptions always use BASE
  assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};
  always_comb begin
    if (mret_take) begin
      next_pc = mepc_q;
    end else if (irq_take && (mtvec_q[1:0] == 2'b01)) begin
      next_pc = tvec_base + XLEN'({irq_cause, 2'b00});
    end else begin
      next_pc = tvec_base;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mtvec_q        <= RESET_MTVEC;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mie_q          <= '0;
      mscratch_q     <= '0;
      redirect_pc_q  <= '0;
    end else begin
      if (csr_we) begin
        unique case (bus.csr_index)
          AddrMstatus: begin
            mstatus_mie_q  <= wval[3];
            mstatus_mpie_q <= wval[7];
          end
          // Reserved MODE values 2/3 leave the current MODE in place
          AddrMtvec:    mtvec_q    <= wval[1] ? {wval[XLEN-1:2], mtvec_q[1:0]} : wval;
          AddrMepc:     mepc_q     <= {wval[XLEN-1:2], 2'b00};
          AddrMcause:   mcause_q   <= wval;
          AddrMtval:    mtval_q    <= wval;
          AddrMie:      mie_q      <= wval & MieMask;
          AddrMscratch: mscratch_q <= wval;
          default: ;
        endcase
      end
      if (trap) begin
        mepc_q         <= {bus.inst_addr[XLEN-1:2], 2'b00};
        mtval_q        <= '0;
        mcause_q       <= irq_take ? {1'b1, {(XLEN-6){1'b0}}, irq_cause}
                                   : XLEN'(bus.inst_ecall ? 5'd11 : 5'd3);
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else if (mret_take) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
      end
      if (trap || mret_take) begin
        redirect_pc_q <= next_pc;
      end
    end
  end

`ifdef CSR_TRAP_UNIT_COUNTERS_EN
  assign retire = commit && !trap;

  // A CSR write to a counter takes precedence over its increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcycle_q     <= '0;
      minstret_q   <= '0;
      cy_inhibit_q <= 1'b0;
      ir_inhibit_q <= 1'b0;
    end else begin
      if (csr_we && (bus.csr_index == AddrMcountinhibit)) begin
        cy_inhibit_q <= wval[0];
        ir_inhibit_q <= wval[2];
      end
      if (csr_we && (bus.csr_index == AddrMcycle)) begin
        mcycle_q <= wval;
      end else if (!cy_inhibit_q) begin
        mcycle_q <= mcycle_q + XLEN'(1);
      end
      if (csr_we && (bus.csr_index == AddrMinstret)) begin
        minstret_q <= wval;
      end else if (retire && !ir_inhibit_q) begin
        minstret_q <= minstret_q + XLEN'(1);
      end
    end
  end
`endif

  // Redirect FSM: state register / next state / outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (trap || mret_take) state_d = StRedirect;
      StRedirect: if (bus.redirect_ready) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.redirect_valid = (state_q == StRedirect);
    bus.busy           = (state_q == StRedirect);
    bus.redirect_pc    = redirect_pc_q;
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
module tb_csr_trap_unit;
  localparam int unsigned XLEN = 64;
  localparam logic [63:0] RstMtvec = 64'h1000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ext_irq = 1'b0, sw_irq = 1'b0, timer_irq = 1'b0;
  logic [3:0] local_irq = 4'h0;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  csr_trap_unit_if #(.XLEN(XLEN)) bus ();

  csr_trap_unit #(
    .XLEN(XLEN),
    .NUM_LOCAL_IRQ(4),
    .RESET_MTVEC(RstMtvec)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .ext_irq(ext_irq),
    .sw_irq(sw_irq),
    .timer_irq(timer_irq),
    .local_irq(local_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [11:0] idx;
    logic [1:0]  ctrl;
    logic [63:0] wd;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [11:0] idx, input logic [1:0] ctrl,
                         input logic [63:0] wd, input logic [63:0] exp);
    vec_t v;
    v.name = name; v.idx = idx; v.ctrl = ctrl; v.wd = wd; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.inst_valid  = 1'b0;
    bus.inst_ecall  = 1'b0;
    bus.inst_ebreak = 1'b0;
    bus.inst_mret   = 1'b0;
    bus.csr_ctrl    = 2'b00;
  endtask

  task automatic csr_op(input logic [11:0] idx, input logic [1:0] ctrl, input logic [63:0] wd);
    bus.inst_valid = 1'b1;
    bus.inst_addr  = 64'h40;
    bus.csr_index  = idx;
    bus.csr_ctrl   = ctrl;
    bus.csr_wdata  = wd;
    step();
    idle_inputs();
  endtask

  task automatic commit(input logic [63:0] addr, input logic ec, input logic eb, input logic mr);
    bus.inst_valid  = 1'b1;
    bus.inst_addr   = addr;
    bus.inst_ecall  = ec;
    bus.inst_ebreak = eb;
    bus.inst_mret   = mr;
    bus.csr_ctrl    = 2'b00;
    step();
    idle_inputs();
  endtask

  // Samples csr_read on the falling edge; consumes one cycle
  task automatic csr_rd(input logic [11:0] idx, output logic [63:0] v);
    bus.csr_index = idx;
    @(negedge clk);
    v = bus.csr_read;
    step();
  endtask

  task automatic check_csr(input string name, input logic [11:0] idx, input logic [63:0] exp);
    logic [63:0] v;
    csr_rd(idx, v);
    check(name, v, exp);
  endtask

  task automatic accept();
    int n;
    n = 0;
    bus.redirect_ready = 1'b1;
    while (bus.redirect_valid && n < 20) begin
      step();
      n++;
    end
    bus.redirect_ready = 1'b0;
    check("redirect_accept_timeout", 64'(n >= 20), 64'd0);
  endtask

  // Scoreboard: expected redirect targets are popped when fetch accepts one
  always @(negedge clk) begin
    if (rst && bus.redirect_valid && bus.redirect_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_redirect: got pc %h expected no redirect", bus.redirect_pc);
      end else begin
        check("redirect_pc_sb", bus.redirect_pc, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v, m0;
    int causes[4];
    causes = '{11, 3, 7, 16};

    idle_inputs();
    bus.inst_addr      = '0;
    bus.csr_index      = '0;
    bus.csr_wdata      = '0;
    bus.redirect_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();

    check("valid_rst", 64'(bus.redirect_valid), 64'd0);
    check("busy_rst", 64'(bus.busy), 64'd0);

    add_vec("mstatus_rst", 12'h300, 2'b00, 64'h0, 64'h1800);
    add_vec("mtvec_rst", 12'h305, 2'b00, 64'h0, RstMtvec);
    add_vec("mepc_rst", 12'h341, 2'b00, 64'h0, 64'h0);
    add_vec("mie_rst", 12'h304, 2'b00, 64'h0, 64'h0);
    add_vec("mtvec_vec", 12'h305, 2'b01, 64'h4000_0001, 64'h4000_0001);
    add_vec("mtvec_badmode", 12'h305, 2'b01, 64'h8000_0003, 64'h8000_0001);
    add_vec("mtvec_clr", 12'h305, 2'b11, 64'h1, 64'h8000_0000);
    add_vec("mepc_align", 12'h341, 2'b01, 64'h1237, 64'h1234);
    add_vec("mie_mask", 12'h304, 2'b01, '1, 64'hF_0888);
    add_vec("mie_clr", 12'h304, 2'b11, 64'h800, 64'hF_0088);
    add_vec("mscratch_wr", 12'h340, 2'b01, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567);
    add_vec("mscratch_set", 12'h340, 2'b10, 64'h8, 64'hDEAD_BEEF_0123_456F);
    add_vec("mscratch_clr", 12'h340, 2'b11, 64'hF, 64'hDEAD_BEEF_0123_4560);
    add_vec("mstatus_set", 12'h300, 2'b10, 64'h8, 64'h1808);
    add_vec("mstatus_all", 12'h300, 2'b01, '1, 64'h1888);
    add_vec("mstatus_zero", 12'h300, 2'b01, 64'h0, 64'h1800);
    add_vec("unimpl", 12'h7C0, 2'b01, '1, 64'h0);
    add_vec("mip_ro", 12'h344, 2'b01, '1, 64'h0);
    add_vec("mtval_wr", 12'h343, 2'b01, 64'h55, 64'h55);
    add_vec("mcause_wr", 12'h342, 2'b01, 64'h5, 64'h5);
`ifdef CSR_TRAP_UNIT_COUNTERS_EN
    add_vec("mcountinh_wr", 12'h320, 2'b01, 64'h7, 64'h5);
    add_vec("mcountinh_clr", 12'h320, 2'b01, 64'h0, 64'h0);
`else
    add_vec("mcycle_absent", 12'hB00, 2'b00, 64'h0, 64'h0);
    add_vec("minstret_absent", 12'hB02, 2'b01, '1, 64'h0);
    add_vec("mcountinh_absent", 12'h320, 2'b01, 64'h5, 64'h0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].ctrl != 2'b00) csr_op(vecs[i].idx, vecs[i].ctrl, vecs[i].wd);
      check_csr(vecs[i].name, vecs[i].idx, vecs[i].exp);
    end

    // Direct-mode ecall, then ebreak
    csr_op(12'h305, 2'b01, 64'h8000_0000);
    csr_op(12'h300, 2'b10, 64'h8);
    exp_q.push_back(64'h8000_0000);
    commit(64'h100, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("ecall_valid", 64'(bus.redirect_valid), 64'd1);
    check("ecall_busy", 64'(bus.busy), 64'd1);
    check("ecall_pc", bus.redirect_pc, 64'h8000_0000);
    step();
    accept();
    check_csr("ecall_mcause", 12'h342, 64'd11);
    check_csr("ecall_mepc", 12'h341, 64'h100);
    check_csr("ecall_mstatus", 12'h300, 64'h1880);
    check_csr("ecall_mtval", 12'h343, 64'h0);
    exp_q.push_back(64'h8000_0000);
    commit(64'h104, 1'b0, 1'b1, 1'b0);
    accept();
    check_csr("ebreak_mcause", 12'h342, 64'd3);
    check_csr("ebreak_mepc", 12'h341, 64'h104);
    check_csr("ebreak_mstatus", 12'h300, 64'h1800);

    // Vectored timer interrupt wins over a CSR-writing instruction
    csr_op(12'h305, 2'b01, 64'h8000_0001);
    csr_op(12'h304, 2'b01, 64'h80);
    timer_irq = 1'b1;
    repeat (3) step();
    csr_op(12'h300, 2'b10, 64'h8);
    check_csr("mip_timer", 12'h344, 64'h80);
`ifdef CSR_TRAP_UNIT_COUNTERS_EN
    csr_rd(12'hB02, m0);
`endif
    exp_q.push_back(64'h8000_001C);
    bus.inst_valid = 1'b1;
    bus.inst_addr  = 64'h200;
    bus.csr_index  = 12'h340;
    bus.csr_ctrl   = 2'b01;
    bus.csr_wdata  = 64'h77;
    step();
    idle_inputs();
    accept();
    check_csr("irq_mcause", 12'h342, 64'h8000_0000_0000_0007);
    check_csr("irq_mepc", 12'h341, 64'h200);
    check_csr("irq_write_dropped", 12'h340, 64'hDEAD_BEEF_0123_4560);
`ifdef CSR_TRAP_UNIT_COUNTERS_EN
    check_csr("irq_no_retire", 12'hB02, m0);
`endif
    timer_irq = 1'b0;

    // Priority: clear the winner each round
    csr_op(12'h304, 2'b01, 64'h1_0888);
    ext_irq = 1'b1; sw_irq = 1'b1; timer_irq = 1'b1; local_irq = 4'h1;
    repeat (3) step();
    for (int k = 0; k < 4; k++) begin
      csr_op(12'h300, 2'b10, 64'h8);
      exp_q.push_back(64'h8000_0000 + 64'(4 * causes[k]));
      commit(64'h400 + 64'(4 * k), 1'b0, 1'b0, 1'b0);
      accept();
      check_csr("prio_mcause", 12'h342, 64'h8000_0000_0000_0000 | 64'(causes[k]));
      case (k)
        0: ext_irq = 1'b0;
        1: sw_irq = 1'b0;
        2: timer_irq = 1'b0;
        default: local_irq = 4'h0;
      endcase
      repeat (3) step();
    end

    // mret under backpressure; commits during REDIRECT must be ignored
    csr_op(12'h300, 2'b01, 64'h80);
    csr_op(12'h341, 2'b01, 64'h300);
    exp_q.push_back(64'h300);
    commit(64'h50, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      bus.inst_valid = 1'b1;
      bus.inst_ecall = 1'b1;
      bus.inst_addr  = 64'h600;
      bus.csr_index  = 12'h340;
      bus.csr_ctrl   = 2'b01;
      bus.csr_wdata  = 64'h1111;
      @(negedge clk);
      check("bp_pc", bus.redirect_pc, 64'h300);
      check("bp_busy", 64'(bus.busy), 64'd1);
      step();
    end
    idle_inputs();
    accept();
    check_csr("mret_mstatus", 12'h300, 64'h1888);
    check_csr("bp_mscratch", 12'h340, 64'hDEAD_BEEF_0123_4560);
    check_csr("bp_mepc", 12'h341, 64'h300);

`ifdef CSR_TRAP_UNIT_COUNTERS_EN
    csr_op(12'h320, 2'b01, 64'h1);
    csr_rd(12'hB00, m0);
    repeat (3) step();
    check_csr("mcycle_frozen", 12'hB00, m0);
    csr_op(12'h320, 2'b01, 64'h0);
    csr_op(12'hB00, 2'b01, '1);
    check_csr("mcycle_max", 12'hB00, '1);
    check_csr("mcycle_wrap", 12'hB00, 64'h0);
    csr_op(12'hB02, 2'b01, 64'h10);
    check_csr("minstret_wr", 12'hB02, 64'h10);
    commit(64'h60, 1'b0, 1'b0, 1'b0);
    check_csr("minstret_inc", 12'hB02, 64'h11);
    csr_op(12'h320, 2'b01, 64'h4);
    commit(64'h64, 1'b0, 1'b0, 1'b0);
    check_csr("minstret_inhibit", 12'hB02, 64'h12);
`endif

    // Reset while a redirect is outstanding
    commit(64'h500, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("pre_rst_valid", 64'(bus.redirect_valid), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_valid", 64'(bus.redirect_valid), 64'd0);
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
    check_csr("post_rst_mtvec", 12'h305, RstMtvec);
    check_csr("post_rst_mstatus", 12'h300, 64'h1800);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
